// File: rtl/i2c_xfer_seq.sv
// i2c_xfer_seq: host-side command sequencer in front of an I2C master.
// Ports: host command (cmd_*), TX FIFO push (tx_*), RX FIFO pop (rx_*),
//        master control/data (mst_*), status (busy, done, err, rx_ovf).
module i2c_xfer_seq #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_rw,
    input  logic [6:0] cmd_addr,
    input  logic [4:0] cmd_len,
    input  logic       tx_wr,
    input  logic [7:0] tx_data,
    output logic       tx_full,
    input  logic       rx_rd,
    output logic [7:0] rx_data,
    output logic       rx_empty,
    output logic       mst_ena,
    output logic       mst_rw,
    output logic [6:0] mst_address,
    output logic [4:0] mst_n_byte,
    output logic [7:0] mst_data_in,
    input  logic [7:0] mst_data_out,
    input  logic       mst_valid,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic       rx_ovf
);

    typedef enum logic [1:0] {
        IDLE,
        CHECK,
        RUN,
        FIN
    } state_t;

    state_t state, state_nx;

    logic [7:0] tx_mem [DEPTH];
    logic [7:0] rx_mem [DEPTH];

    logic [AW:0] tx_wp, tx_rp, rx_wp, rx_rp;
    logic [AW:0] tx_cnt, rx_cnt;
    logic        tx_empty, rx_full;
    logic        tx_push, tx_pop, rx_push, rx_push_ok, rx_pop;

    logic       lat_rw;
    logic [6:0] lat_addr;
    logic [4:0] lat_len;
    logic [4:0] cnt;
    logic       err_q;

    logic zero_len, oversize, tx_ok, rx_ok;

    // FIFO status: equal pointers = empty, MSB-differ with equal index = full
    assign tx_cnt   = tx_wp - tx_rp;
    assign rx_cnt   = rx_wp - rx_rp;
    assign tx_empty = (tx_wp == tx_rp);
    assign tx_full  = (tx_wp[AW] != tx_rp[AW]) &&
                      (tx_wp[AW-1:0] == tx_rp[AW-1:0]);
    assign rx_empty = (rx_wp == rx_rp);
    assign rx_full  = (rx_wp[AW] != rx_rp[AW]) &&
                      (rx_wp[AW-1:0] == rx_rp[AW-1:0]);

    // A pop in the same cycle frees the slot, so a push at full still lands
    assign tx_pop     = (state == RUN) && mst_valid && !lat_rw && !tx_empty;
    assign tx_push    = tx_wr && (!tx_full || tx_pop);
    assign rx_pop     = rx_rd && !rx_empty;
    assign rx_push    = (state == RUN) && mst_valid && lat_rw;
    assign rx_push_ok = rx_push && (!rx_full || rx_pop);

    // Resource checks use the occupancy before any same-cycle push
    assign zero_len = (lat_len == 5'd0);
    assign oversize = int'(lat_len) > DEPTH;
    assign tx_ok    = int'(tx_cnt) >= int'(lat_len);
    assign rx_ok    = (DEPTH - int'(rx_cnt)) >= int'(lat_len);

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (cmd_valid) state_nx = CHECK;
            end
            CHECK: begin
                if (zero_len || oversize) state_nx = FIN;
                else if (lat_rw ? rx_ok : tx_ok) state_nx = RUN;
            end
            RUN: begin
                if (mst_valid && cnt == 5'd1) state_nx = FIN;
            end
            FIN: begin
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    assign cmd_ready   = (state == IDLE);
    assign mst_ena     = (state == RUN);
    assign busy        = (state != IDLE);
    assign done        = (state == FIN);
    assign err         = (state == FIN) && err_q;
    assign mst_rw      = lat_rw;
    assign mst_address = lat_addr;
    assign mst_n_byte  = lat_len;

    // Heads read as zero when empty so outputs are defined out of reset
    assign mst_data_in = tx_empty ? 8'h00 : tx_mem[tx_rp[AW-1:0]];
    assign rx_data     = rx_empty ? 8'h00 : rx_mem[rx_rp[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            lat_rw   <= 1'b0;
            lat_addr <= 7'd0;
            lat_len  <= 5'd0;
            cnt      <= 5'd0;
            err_q    <= 1'b0;
            rx_ovf   <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == IDLE && cmd_valid) begin
                lat_rw   <= cmd_rw;
                lat_addr <= cmd_addr;
                lat_len  <= cmd_len;
            end
            if (state == CHECK) err_q <= oversize;
            if (state == CHECK && state_nx == RUN) cnt <= lat_len;
            else if (state == RUN && mst_valid) cnt <= cnt - 5'd1;
            if (rx_push && !rx_push_ok) rx_ovf <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_wp <= '0;
            tx_rp <= '0;
            rx_wp <= '0;
            rx_rp <= '0;
        end else begin
            if (tx_push)    tx_wp <= tx_wp + 1'b1;
            if (tx_pop)     tx_rp <= tx_rp + 1'b1;
            if (rx_push_ok) rx_wp <= rx_wp + 1'b1;
            if (rx_pop)     rx_rp <= rx_rp + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (tx_push)    tx_mem[tx_wp[AW-1:0]] <= tx_data;
        if (rx_push_ok) rx_mem[rx_wp[AW-1:0]] <= mst_data_out;
    end

endmodule

// File: tb/tb_i2c_xfer_seq.sv
// tb_i2c_xfer_seq: directed plus random stimulus for i2c_xfer_seq,
// checked every cycle against a queue-based transaction model.
module tb_i2c_xfer_seq;

    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid, cmd_ready, cmd_rw;
    logic [6:0] cmd_addr;
    logic [4:0] cmd_len;
    logic       tx_wr, tx_full;
    logic [7:0] tx_data;
    logic       rx_rd, rx_empty;
    logic [7:0] rx_data;
    logic       mst_ena, mst_rw, mst_valid;
    logic [6:0] mst_address;
    logic [4:0] mst_n_byte;
    logic [7:0] mst_data_in, mst_data_out;
    logic       busy, done, err, rx_ovf;

    int checks = 0;
    int failures = 0;
    bit go = 0;

    i2c_xfer_seq #(.DEPTH(DEPTH), .AW(4)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_rw(cmd_rw), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .tx_wr(tx_wr), .tx_data(tx_data), .tx_full(tx_full),
        .rx_rd(rx_rd), .rx_data(rx_data), .rx_empty(rx_empty),
        .mst_ena(mst_ena), .mst_rw(mst_rw), .mst_address(mst_address),
        .mst_n_byte(mst_n_byte), .mst_data_in(mst_data_in),
        .mst_data_out(mst_data_out), .mst_valid(mst_valid),
        .busy(busy), .done(done), .err(err), .rx_ovf(rx_ovf)
    );

    always #5 clk = ~clk;

    // Transaction model. phase: 0 idle, 1 resource check, 2 transfer, 3 done
    logic [7:0] txq[$];
    logic [7:0] rxq[$];
    int         phase, remain, txn, rxn;
    bit         m_rw, m_err, m_ovf;
    logic [6:0] m_addr;
    logic [4:0] m_len;
    bit         pop_t, push_t, pop_r, push_r;

    task automatic model_reset();
        txq.delete();
        rxq.delete();
        phase = 0;
        remain = 0;
        m_rw = 0;
        m_err = 0;
        m_ovf = 0;
        m_addr = '0;
        m_len = '0;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                model_reset();
            end else begin
                txn = txq.size();
                rxn = rxq.size();
                pop_t  = (phase == 2) && mst_valid && !m_rw && txn > 0;
                push_t = tx_wr && (txn < DEPTH || pop_t);
                pop_r  = rx_rd && rxn > 0;
                push_r = (phase == 2) && mst_valid && m_rw;
                if (pop_t) void'(txq.pop_front());
                if (push_t) txq.push_back(tx_data);
                if (pop_r) void'(rxq.pop_front());
                if (push_r) begin
                    if (rxn < DEPTH || pop_r) rxq.push_back(mst_data_out);
                    else m_ovf = 1;
                end
                case (phase)
                    0: if (cmd_valid) begin
                        m_rw = cmd_rw;
                        m_addr = cmd_addr;
                        m_len = cmd_len;
                        phase = 1;
                    end
                    1: begin
                        if (m_len == 0) begin
                            m_err = 0;
                            phase = 3;
                        end else if (int'(m_len) > DEPTH) begin
                            m_err = 1;
                            phase = 3;
                        end else if ((!m_rw && txn >= int'(m_len)) ||
                                     (m_rw && DEPTH - rxn >= int'(m_len))) begin
                            m_err = 0;
                            remain = int'(m_len);
                            phase = 2;
                        end
                    end
                    2: if (mst_valid) begin
                        remain = remain - 1;
                        if (remain == 0) phase = 3;
                    end
                    default: phase = 0;
                endcase
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %0h expected %0h",
                     nm, $time, act, exp);
        end
    endtask

    // Per-cycle comparison against the model, on the falling edge
    initial begin
        forever begin
            @(negedge clk);
            if (go && !rst) begin
                chk("cmd_ready", 32'(cmd_ready), 32'(phase == 0));
                chk("busy", 32'(busy), 32'(phase != 0));
                chk("mst_ena", 32'(mst_ena), 32'(phase == 2));
                chk("done", 32'(done), 32'(phase == 3));
                chk("err", 32'(err), 32'(phase == 3 && m_err));
                chk("mst_rw", 32'(mst_rw), 32'(m_rw));
                chk("mst_address", 32'(mst_address), 32'(m_addr));
                chk("mst_n_byte", 32'(mst_n_byte), 32'(m_len));
                chk("tx_full", 32'(tx_full), 32'(txq.size() == DEPTH));
                chk("rx_empty", 32'(rx_empty), 32'(rxq.size() == 0));
                chk("rx_ovf", 32'(rx_ovf), 32'(m_ovf));
                chk("mst_data_in", 32'(mst_data_in),
                    32'(txq.size() > 0 ? txq[0] : 8'h00));
                chk("rx_data", 32'(rx_data),
                    32'(rxq.size() > 0 ? rxq[0] : 8'h00));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        cmd_valid = 0;
        cmd_rw = 0;
        cmd_addr = '0;
        cmd_len = '0;
        tx_wr = 0;
        tx_data = '0;
        rx_rd = 0;
        mst_valid = 0;
        mst_data_out = '0;
    endtask

    task automatic push(input logic [7:0] b);
        tx_wr = 1;
        tx_data = b;
        tick();
        tx_wr = 0;
    endtask

    task automatic send_cmd(input logic rw, input logic [6:0] a,
                            input logic [4:0] n);
        cmd_valid = 1;
        cmd_rw = rw;
        cmd_addr = a;
        cmd_len = n;
        tick();
        cmd_valid = 0;
    endtask

    task automatic mvalid(input logic [7:0] d);
        mst_valid = 1;
        mst_data_out = d;
        tick();
        mst_valid = 0;
    endtask

    initial begin
        logic [7:0] rd_exp [4];
        rd_exp = '{8'h11, 8'h22, 8'h33, 8'h44};
        clear_inputs();
        rst = 1;
        #12;
        chk("reset mst_ena", 32'(mst_ena), 0);
        chk("reset busy", 32'(busy), 0);
        chk("reset done", 32'(done), 0);
        chk("reset err", 32'(err), 0);
        chk("reset tx_full", 32'(tx_full), 0);
        chk("reset rx_empty", 32'(rx_empty), 1);
        chk("reset rx_ovf", 32'(rx_ovf), 0);
        chk("reset mst_data_in", 32'(mst_data_in), 0);
        @(posedge clk);
        #1;
        rst = 0;
        go = 1;
        tick();

        // Write of three queued bytes
        push(8'hA1);
        push(8'hB2);
        push(8'hC3);
        send_cmd(0, 7'h50, 5'd3);
        chk("wr3 check mst_ena", 32'(mst_ena), 0);
        tick();
        chk("wr3 run mst_ena", 32'(mst_ena), 1);
        chk("wr3 address", 32'(mst_address), 32'h50);
        chk("wr3 byte0", 32'(mst_data_in), 32'hA1);
        mvalid(8'h00);
        chk("wr3 byte1", 32'(mst_data_in), 32'hB2);
        mvalid(8'h00);
        chk("wr3 byte2", 32'(mst_data_in), 32'hC3);
        mvalid(8'h00);
        chk("wr3 done", 32'(done), 1);
        chk("wr3 ena low", 32'(mst_ena), 0);
        chk("wr3 err", 32'(err), 0);
        tick();
        chk("wr3 idle done", 32'(done), 0);
        chk("wr3 tx drained", 32'(mst_data_in), 0);

        // Write stalls until its second byte arrives
        push(8'h5A);
        send_cmd(0, 7'h12, 5'd2);
        tick();
        chk("stall ena", 32'(mst_ena), 0);
        chk("stall busy", 32'(busy), 1);
        push(8'h6B);
        chk("stall push cycle", 32'(mst_ena), 0);
        tick();
        chk("stall run", 32'(mst_ena), 1);
        mvalid(8'h00);
        mvalid(8'h00);
        tick();

        // Read of four bytes
        send_cmd(1, 7'h3C, 5'd4);
        tick();
        chk("rd4 ena", 32'(mst_ena), 1);
        chk("rd4 rw", 32'(mst_rw), 1);
        for (int i = 0; i < 4; i++) mvalid(rd_exp[i]);
        chk("rd4 done", 32'(done), 1);
        tick();
        for (int i = 0; i < 4; i++) begin
            chk("rd4 data", 32'(rx_data), 32'(rd_exp[i]));
            rx_rd = 1;
            tick();
            rx_rd = 0;
        end
        chk("rd4 empty", 32'(rx_empty), 1);
        chk("rd4 ovf", 32'(rx_ovf), 0);

        // Zero and oversize lengths
        send_cmd(0, 7'h01, 5'd0);
        tick();
        chk("len0 done", 32'(done), 1);
        chk("len0 err", 32'(err), 0);
        chk("len0 ena", 32'(mst_ena), 0);
        tick();
        send_cmd(1, 7'h02, 5'd17);
        tick();
        chk("len17 done", 32'(done), 1);
        chk("len17 err", 32'(err), 1);
        chk("len17 ena", 32'(mst_ena), 0);
        tick();

        // TX full, ignored push, push+pop at full, full drain
        for (int i = 0; i < 16; i++) push(8'(8'h40 + i));
        chk("txfull set", 32'(tx_full), 1);
        push(8'hFF);
        chk("txfull hold", 32'(tx_full), 1);
        send_cmd(0, 7'h22, 5'd1);
        tick();
        tx_wr = 1;
        tx_data = 8'h99;
        mvalid(8'h00);
        tx_wr = 0;
        chk("pushpop full", 32'(tx_full), 1);
        chk("pushpop head", 32'(mst_data_in), 32'h41);
        tick();
        send_cmd(0, 7'h22, 5'd16);
        tick();
        for (int i = 0; i < 16; i++) mvalid(8'h00);
        chk("drain done", 32'(done), 1);
        tick();
        chk("drain empty", 32'(mst_data_in), 0);

        // Pointer wrap: 42 more bytes with pushes interleaved during RUN
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 14; i++) push(8'($urandom));
            send_cmd(0, 7'h33, 5'd14);
            tick();
            for (int i = 0; i < 14; i++) begin
                tx_wr = 1'($urandom);
                tx_data = 8'($urandom);
                mvalid(8'h00);
                tx_wr = 0;
            end
            tick();
        end

        // Reset during a read transfer
        for (int i = 0; i < 20; i++) begin
            rx_rd = 1;
            tick();
        end
        rx_rd = 0;
        send_cmd(1, 7'h3C, 5'd3);
        tick();
        mvalid(8'h5A);
        rst = 1;
        #1;
        chk("rst ena", 32'(mst_ena), 0);
        chk("rst busy", 32'(busy), 0);
        chk("rst rx_empty", 32'(rx_empty), 1);
        @(posedge clk);
        #1;
        rst = 0;
        tick();
        chk("rst no done", 32'(done), 0);
        send_cmd(1, 7'h3C, 5'd2);
        tick();
        mvalid(8'h77);
        mvalid(8'h88);
        chk("post rst done", 32'(done), 1);
        tick();
        chk("post rst d0", 32'(rx_data), 32'h77);
        rx_rd = 1;
        tick();
        rx_rd = 0;
        chk("post rst d1", 32'(rx_data), 32'h88);
        rx_rd = 1;
        tick();
        rx_rd = 0;

        // Random traffic
        for (int c = 0; c < 4000; c++) begin
            cmd_valid = ($urandom % 4) == 0;
            cmd_rw = 1'($urandom);
            cmd_addr = 7'($urandom);
            cmd_len = 5'($urandom_range(0, 20));
            tx_wr = 1'($urandom);
            tx_data = 8'($urandom);
            rx_rd = ($urandom % 3) == 0;
            mst_valid = 1'($urandom);
            mst_data_out = 8'($urandom);
            tick();
        end
        clear_inputs();
        repeat (4) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
